// File: rtl/mgmt_gpio_pkg.sv
// rtl/mgmt_gpio_pkg.sv - register map, field positions and blink FSM states for mgmt_gpio_ctrl
package mgmt_gpio_pkg;

  // Register index taken from wb_adr_i[4:2] (byte offset / 4)
  localparam logic [2:0] REG_DATA   = 3'd0;  // 0x00
  localparam logic [2:0] REG_OE     = 3'd1;  // 0x04
  localparam logic [2:0] REG_CTRL   = 3'd2;  // 0x08
  localparam logic [2:0] REG_PERIOD = 3'd3;  // 0x0C
  localparam logic [2:0] REG_STATUS = 3'd4;  // 0x10
  localparam logic [2:0] REG_IRQ_EN = 3'd5;  // 0x14

  localparam int DATA_OUT_BIT    = 0;
  localparam int DATA_IN_BIT     = 1;
  localparam int OE_BIT          = 0;
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_STOP_BIT   = 1;
  localparam int CTRL_COUNT_LSB  = 8;
  localparam int COUNT_W         = 8;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_EDGE_BIT = 2;

  typedef enum logic [1:0] {
    BLINK_IDLE = 2'd0,
    BLINK_HIGH = 2'd1,
    BLINK_LOW  = 2'd2
  } blink_state_e;

  // Byte-lane merge: lanes with sel set take the new value, others keep the old one
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_blink_gen.sv
// rtl/gpio_blink_gen.sv - blink timer FSM producing a pulse train on the pad level
module gpio_blink_gen
  import mgmt_gpio_pkg::*;
#(
  parameter int BLINK_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [BLINK_W-1:0] period,
  input  logic [COUNT_W-1:0] count,
  output logic               level,
  output logic               busy,
  output logic               done_pulse
);

  localparam logic [BLINK_W-1:0] ONE = {{(BLINK_W-1){1'b0}}, 1'b1};

  blink_state_e       state_q, state_d;
  logic [BLINK_W-1:0] cnt_q, cnt_d;
  logic [BLINK_W-1:0] half_q, half_d;
  logic [COUNT_W-1:0] target_q, target_d;
  logic [COUNT_W-1:0] pulses_q, pulses_d;
  logic [COUNT_W-1:0] pulses_inc;
  logic [BLINK_W-1:0] period_eff;
  logic               level_q, level_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state logic: stop beats everything, start only honoured from IDLE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    target_d   = target_q;
    pulses_d   = pulses_q;
    level_d    = level_q;
    done_d     = 1'b0;
    period_eff = (period == '0) ? ONE : period;
    pulses_inc = pulses_q + 1'b1;
    if (stop) begin
      state_d = BLINK_IDLE;
      level_d = 1'b0;
    end else begin
      case (state_q)
        BLINK_IDLE: begin
          if (start) begin
            state_d  = BLINK_HIGH;
            level_d  = 1'b1;
            half_d   = period_eff;
            cnt_d    = period_eff;
            target_d = count;
            pulses_d = '0;
          end
        end
        BLINK_HIGH: begin
          if (cnt_q == ONE) begin
            state_d = BLINK_LOW;
            level_d = 1'b0;
            cnt_d   = half_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        BLINK_LOW: begin
          if (cnt_q == ONE) begin
            pulses_d = pulses_inc;
            if (target_q != '0 && pulses_inc == target_q) begin
              state_d = BLINK_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = BLINK_HIGH;
              level_d = 1'b1;
              cnt_d   = half_q;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          state_d = BLINK_IDLE;
          level_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != BLINK_IDLE);
  end

  // FSM state, timer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BLINK_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      target_q <= '0;
      pulses_q <= '0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      target_q <= target_d;
      pulses_q <= pulses_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign level      = level_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;

endmodule

// File: rtl/mgmt_gpio_ctrl.sv
// rtl/mgmt_gpio_ctrl.sv - Wishbone-managed single GPIO with blink generator and interrupts
module mgmt_gpio_ctrl
  import mgmt_gpio_pkg::*;
#(
  parameter int                 BLINK_W  = 24,
  parameter logic [BLINK_W-1:0] RST_HALF = 24'd1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        gpio_in_pad,
  output logic        gpio_out_pad,
  output logic        gpio_oeb_pad,
  output logic        irq_o
);

  logic               ack_q, ack_d;
  logic [31:0]        dat_o_q, dat_o_d;
  logic               data_out_q, data_out_d;
  logic               oe_q, oe_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [BLINK_W-1:0] period_q, period_d;
  logic               done_q, done_d;
  logic               edge_q, edge_d;
  logic [1:0]         irq_en_q, irq_en_d;
  logic               irq_q, irq_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               sync3_q, sync3_d;

  logic               bus_req, bus_wr;
  logic [2:0]         reg_idx;
  logic [31:0]        rdata, wr_merged;
  logic               wr_data, wr_oe, wr_ctrl, wr_period, wr_status, wr_irq_en;
  logic               blink_start, blink_stop, clr_done, clr_edge, edge_set;
  logic               blink_level, blink_busy, blink_done;
  logic               unused_bits;

  // Read mux, write decode and next-state for every register
  always_comb begin
    bus_req = wb_cyc_i & wb_stb_i & ~ack_q;
    // The write commits on the ack cycle while the master still holds the bus
    bus_wr  = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
    reg_idx = wb_adr_i[4:2];

    rdata = '0;
    case (reg_idx)
      REG_DATA: begin
        rdata[DATA_OUT_BIT] = data_out_q;
        rdata[DATA_IN_BIT]  = sync2_q;
      end
      REG_OE:     rdata[OE_BIT] = oe_q;
      REG_CTRL:   rdata[CTRL_COUNT_LSB +: COUNT_W] = count_q;
      REG_PERIOD: rdata[BLINK_W-1:0] = period_q;
      REG_STATUS: begin
        rdata[STATUS_BUSY_BIT] = blink_busy;
        rdata[STATUS_DONE_BIT] = done_q;
        rdata[STATUS_EDGE_BIT] = edge_q;
      end
      REG_IRQ_EN: rdata[1:0] = irq_en_q;
      default:    rdata = '0;
    endcase

    wr_merged = merge_lanes(rdata, wb_dat_i, wb_sel_i);
    wr_data   = bus_wr && (reg_idx == REG_DATA);
    wr_oe     = bus_wr && (reg_idx == REG_OE);
    wr_ctrl   = bus_wr && (reg_idx == REG_CTRL);
    wr_period = bus_wr && (reg_idx == REG_PERIOD);
    wr_status = bus_wr && (reg_idx == REG_STATUS);
    wr_irq_en = bus_wr && (reg_idx == REG_IRQ_EN);

    blink_start = wr_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_START_BIT];
    blink_stop  = wr_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_STOP_BIT];
    clr_done    = wr_status & wb_sel_i[0] & wb_dat_i[STATUS_DONE_BIT];
    clr_edge    = wr_status & wb_sel_i[0] & wb_dat_i[STATUS_EDGE_BIT];

    data_out_d = wr_data   ? wr_merged[DATA_OUT_BIT] : data_out_q;
    oe_d       = wr_oe     ? wr_merged[OE_BIT] : oe_q;
    // Count fed to the blink generator already includes a same-write update
    count_d    = wr_ctrl   ? wr_merged[CTRL_COUNT_LSB +: COUNT_W] : count_q;
    period_d   = wr_period ? wr_merged[BLINK_W-1:0] : period_q;
    irq_en_d   = wr_irq_en ? wr_merged[1:0] : irq_en_q;

    sync1_d  = gpio_in_pad;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    edge_set = sync2_q ^ sync3_q;

    // Set events win over a coincident W1C clear
    done_d = blink_done | (done_q & ~clr_done);
    edge_d = edge_set   | (edge_q & ~clr_edge);
    irq_d  = |({edge_q, done_q} & irq_en_q);

    ack_d   = bus_req;
    dat_o_d = (bus_req & ~wb_we_i) ? rdata : '0;
  end

  // Register file, bus response and input synchronizer
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      data_out_q <= 1'b0;
      oe_q       <= 1'b0;
      count_q    <= '0;
      period_q   <= RST_HALF;
      done_q     <= 1'b0;
      edge_q     <= 1'b0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
      data_out_q <= data_out_d;
      oe_q       <= oe_d;
      count_q    <= count_d;
      period_q   <= period_d;
      done_q     <= done_d;
      edge_q     <= edge_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
    end
  end

  gpio_blink_gen #(
    .BLINK_W (BLINK_W)
  ) u_blink (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .start      (blink_start),
    .stop       (blink_stop),
    .period     (period_q),
    .count      (count_d),
    .level      (blink_level),
    .busy       (blink_busy),
    .done_pulse (blink_done)
  );

  assign unused_bits  = ^{wb_adr_i[1:0], wr_merged};
  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_o_q;
  assign gpio_oeb_pad = ~oe_q;
  assign gpio_out_pad = blink_busy ? blink_level : data_out_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// tb/tb_mgmt_gpio_ctrl.sv - self-checking bench for mgmt_gpio_ctrl
module tb_mgmt_gpio_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        gpio_in_pad = 1'b0;
  logic        gpio_out_pad;
  logic        gpio_oeb_pad;
  logic        irq_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];
  logic        lv_q[$];

  always #5 sys_clk = ~sys_clk;

  mgmt_gpio_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_sel_i     (wb_sel_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .gpio_in_pad  (gpio_in_pad),
    .gpio_out_pad (gpio_out_pad),
    .gpio_oeb_pad (gpio_oeb_pad),
    .irq_o        (irq_o)
  );

  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output logic ok);
    ok = 1'b0;
    rdat = '0;
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) begin
        ok = 1'b1;
        rdat = wb_dat_o;
      end
    end
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                    input string name);
    logic [31:0] rd;
    logic ok;
    wb_xfer(1'b1, adr, dat, sel, rd, ok);
    checks++;
    if (ok !== 1'b1) begin
      $display("FAIL %s: write ack got %b want 1", name, ok);
      errors++;
    end
  endtask

  task automatic rd_chk(input logic [4:0] adr, input logic [31:0] exp, input string name);
    logic [31:0] rd, e;
    logic ok;
    sb_q.push_back(exp);
    wb_xfer(1'b0, adr, 32'h0, 4'h0, rd, ok);
    e = sb_q.pop_front();
    checks++;
    if (ok !== 1'b1) begin
      $display("FAIL %s: read ack got %b want 1", name, ok);
      errors++;
    end else if (rd !== e) begin
      $display("FAIL %s: read got 0x%08h want 0x%08h", name, rd, e);
      errors++;
    end
  endtask

  task automatic chk1(input logic got, input logic exp, input string name);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %b want %b", name, got, exp);
      errors++;
    end
  endtask

  // Sample the pad once per cycle and pop the expected level for each
  task automatic monitor_levels(input int n, input logic prev_in, input string name,
                                output int falls);
    logic prev, lvl, e;
    prev = prev_in;
    falls = 0;
    for (int i = 0; i < n; i++) begin
      lvl = gpio_out_pad;
      if (prev && !lvl) falls++;
      prev = lvl;
      e = lv_q.pop_front();
      checks++;
      if (lvl !== e) begin
        $display("FAIL %s: cycle %0d level got %b want %b", name, i, lvl, e);
        errors++;
      end
      @(posedge sys_clk); #1;
    end
    if (prev && !gpio_out_pad) falls++;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk1(wb_ack_o, 1'b0, "reset_ack");
    chk1(gpio_oeb_pad, 1'b1, "reset_oeb");
    chk1(gpio_out_pad, 1'b0, "reset_out");
    chk1(irq_o, 1'b0, "reset_irq");
    checks++;
    if (wb_dat_o !== 32'h0) begin
      $display("FAIL reset_dat_o: got 0x%08h want 0x00000000", wb_dat_o);
      errors++;
    end
    sys_rst = 1'b0;
    rd_chk(5'h00, 32'h0, "reset_data");
    rd_chk(5'h04, 32'h0, "reset_oe");
    rd_chk(5'h08, 32'h0, "reset_ctrl");
    rd_chk(5'h0C, 32'd1000, "reset_period");
    rd_chk(5'h10, 32'h0, "reset_status");
    rd_chk(5'h14, 32'h0, "reset_irq_en");
    rd_chk(5'h18, 32'h0, "reset_unmapped18");
    rd_chk(5'h1C, 32'h0, "reset_unmapped1c");
  endtask

  task automatic test_data_oe();
    wr(5'h04, 32'h1, 4'hF, "oe_wr");
    chk1(gpio_oeb_pad, 1'b0, "oe_oeb_low");
    wr(5'h00, 32'h1, 4'hF, "data_wr");
    chk1(gpio_out_pad, 1'b1, "data_out_high");
    rd_chk(5'h00, 32'h1, "data_readback");
    wr(5'h00, 32'h0, 4'b0010, "data_wr_lane1");
    rd_chk(5'h00, 32'h1, "data_lane_masked");
    wr(5'h0C, 32'h00AABBCC, 4'b0010, "period_wr_lane1");
    rd_chk(5'h0C, 32'h0000BBE8, "period_lane_merge");
    rd_chk(5'h0F, 32'h0000BBE8, "period_low_addr_bits_ignored");
    wr(5'h18, 32'hFFFFFFFF, 4'hF, "unmapped_wr");
    rd_chk(5'h18, 32'h0, "unmapped_read");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  adrs[3];
    logic [31:0] e;
    logic        got;
    adrs[0] = 5'h00; adrs[1] = 5'h04; adrs[2] = 5'h0C;
    sb_q.push_back(32'h1);
    sb_q.push_back(32'h1);
    sb_q.push_back(32'h0000BBE8);
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'h0;
    wb_adr_i = adrs[0];
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(posedge sys_clk); #1;
        if (wb_ack_o) got = 1'b1;
      end
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
        $display("FAIL b2b_ack_%0d: ack got 0 want 1", i);
        errors++;
      end else if (wb_dat_o !== e) begin
        $display("FAIL b2b_data_%0d: got 0x%08h want 0x%08h", i, wb_dat_o, e);
        errors++;
      end
      if (i < 2) wb_adr_i = adrs[i+1];
      @(posedge sys_clk); #1;
      chk1(wb_ack_o, 1'b0, "b2b_ack_one_cycle");
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic run_blink(input logic dout, input string name);
    int falls;
    wr(5'h0C, 32'd4, 4'hF, "blink_period_wr");
    for (int p = 0; p < 10; p++) begin
      for (int h = 0; h < 4; h++) lv_q.push_back(1'b1);
      for (int l = 0; l < 4; l++) lv_q.push_back(1'b0);
    end
    wr(5'h08, 32'h00000A01, 4'b0011, "blink_start_wr");
    monitor_levels(80, dout, name, falls);
    chk1(gpio_out_pad, dout, "blink_returns_to_data");
    checks++;
    if (falls != 10) begin
      $display("FAIL %s_falls: got %0d want 10", name, falls);
      errors++;
    end
    rd_chk(5'h10, 32'h2, "blink_done_not_busy");
    wr(5'h10, 32'h2, 4'h1, "blink_done_clr");
    rd_chk(5'h10, 32'h0, "blink_done_cleared");
  endtask

  task automatic test_blink();
    run_blink(1'b1, "blink");
  endtask

  task automatic test_continuous();
    int falls;
    wr(5'h00, 32'h0, 4'hF, "cont_data0");
    wr(5'h0C, 32'h0, 4'hF, "cont_period0");
    for (int i = 0; i < 8; i++) lv_q.push_back((i % 2) == 0);
    wr(5'h08, 32'h00000001, 4'b0011, "cont_start");
    monitor_levels(8, 1'b0, "cont_toggle", falls);
    rd_chk(5'h10, 32'h1, "cont_busy");
    wr(5'h08, 32'h2, 4'h1, "cont_stop");
    chk1(gpio_out_pad, 1'b0, "cont_stopped_now");
    @(posedge sys_clk); #1;
    chk1(gpio_out_pad, 1'b0, "cont_stopped_next");
    rd_chk(5'h10, 32'h0, "cont_idle_no_done");
    wr(5'h08, 32'h3, 4'h1, "stop_start_same");
    chk1(gpio_out_pad, 1'b0, "stop_priority_out");
    rd_chk(5'h10, 32'h0, "stop_priority_status");
  endtask

  task automatic wait_irq(input string name, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge sys_clk); #1;
      lat++;
      if (irq_o) got = 1'b1;
    end
    checks++;
    if (!got) begin
      $display("FAIL %s: irq got 0 want 1 within 10 cycles", name);
      errors++;
    end
  endtask

  task automatic test_irq();
    int lat;
    wr(5'h14, 32'h2, 4'hF, "irq_en_wr");
    rd_chk(5'h14, 32'h2, "irq_en_read");
    gpio_in_pad = 1'b1;
    wait_irq("irq_rise", lat);
    checks++;
    if (lat < 3 || lat > 4) begin
      $display("FAIL irq_latency: got %0d want 3..4", lat);
      errors++;
    end
    rd_chk(5'h10, 32'h4, "irq_edge_status");
    rd_chk(5'h00, 32'h2, "irq_sync_input");
    wr(5'h10, 32'h4, 4'h1, "edge_clr");
    rd_chk(5'h10, 32'h0, "edge_cleared");
    chk1(irq_o, 1'b0, "irq_cleared");
    gpio_in_pad = 1'b0;
    wait_irq("irq_fall", lat);
    gpio_in_pad = 1'b1;
    wr(5'h10, 32'h4, 4'h1, "edge_clr_coincident");
    rd_chk(5'h10, 32'h4, "edge_set_wins");
    chk1(irq_o, 1'b1, "irq_set_wins");
    wr(5'h10, 32'h4, 4'h1, "edge_clr_final");
    rd_chk(5'h10, 32'h0, "edge_cleared_final");
    chk1(irq_o, 1'b0, "irq_cleared_final");
    wr(5'h14, 32'h0, 4'hF, "irq_en_off");
  endtask

  task automatic test_reset_mid();
    wr(5'h0C, 32'd4, 4'hF, "mid_period");
    wr(5'h08, 32'h00000A01, 4'b0011, "mid_start");
    rd_chk(5'h10, 32'h1, "mid_busy");
    chk1(gpio_out_pad, 1'b1, "mid_high");
    sys_rst = 1'b1;
    gpio_in_pad = 1'b0;
    #1;
    chk1(gpio_out_pad, 1'b0, "mid_rst_out");
    chk1(gpio_oeb_pad, 1'b1, "mid_rst_oeb");
    chk1(wb_ack_o, 1'b0, "mid_rst_ack");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    rd_chk(5'h10, 32'h0, "mid_status_after_rst");
    rd_chk(5'h0C, 32'd1000, "mid_period_after_rst");
    run_blink(1'b0, "rerun");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_data_oe();
    test_back_to_back();
    test_blink();
    test_continuous();
    test_irq();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mgmt_gpio_ctrl.md
MGMT_GPIO_CTRL -- requirements
Module: mgmt_gpio_ctrl

Interface
REQ-001 Parameter: BLINK_W, default 24, width of the blink half-period counter.
REQ-002 Parameter: RST_HALF, default 24'd1000, reset value of BLINK_PERIOD.
REQ-003 Port: sys_clk  in  1  single clock for all logic.
REQ-004 Port: sys_rst  in  1  reset; asynchronous and active-high.
REQ-005 Port: wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic slave controls.
REQ-006 Port: wb_adr_i  in  5  byte address; bits [4:2] select the register; bits [1:0] ignored.
REQ-007 Port: wb_sel_i  in  4  byte-lane write enables.
REQ-008 Port: wb_dat_i  in  32  write data.
REQ-009 Port: wb_dat_o  out  32  read data.
REQ-010 Port: wb_ack_o  out  1  one-cycle acknowledge.
REQ-011 Port: gpio_in_pad  in  1  asynchronous pad input.
REQ-012 Port: gpio_out_pad  out  1  pad output value.
REQ-013 Port: gpio_oeb_pad  out  1  pad output enable, active-low.
REQ-014 Port: irq_o  out  1  level interrupt.

Function
REQ-015 wb_ack_o SHALL assert exactly one cycle after the first cycle in which wb_cyc_i & wb_stb_i & !wb_ack_o holds, giving one-wait-state transfers that never stall.
REQ-016 Register map:
  - 0x00 DATA: [0] out RW; [1] synchronized input RO.
  - 0x04 OE: [0] oe RW.
  - 0x08 BLINK_CTRL: [0] start, write-1 self-clearing, reads 0; [1] stop, write-1 self-clearing, reads 0; [15:8] pulse count RW, 0 = continuous.
  - 0x0C BLINK_PERIOD: [BLINK_W-1:0] half-period in clocks, RW.
  - 0x10 STATUS: [0] busy RO; [1] done W1C; [2] edge W1C.
  - 0x14 IRQ_EN: [1:0] RW.
  - Unmapped addresses read 0 and ignore writes.
REQ-017 Writes SHALL honour wb_sel_i per byte lane and take effect on the ack cycle.
REQ-018 gpio_in_pad SHALL pass through a 2-flop synchronizer; STATUS.edge SHALL set on any change of the synchronized value.
REQ-019 gpio_oeb_pad SHALL equal !OE.oe.
REQ-020 gpio_out_pad SHALL equal DATA.out when the blink FSM is IDLE, and the FSM-driven level otherwise.
REQ-021 Blink FSM states: IDLE, HIGH, LOW.
  - IDLE->HIGH on a start write; output 1; counter loaded with BLINK_PERIOD.
  - HIGH->LOW when the counter reaches 1; output 0; counter reloaded.
  - At LOW expiry, the completed-pulse count increments; if count!=0 and completed==count -> IDLE with done set, else -> HIGH.
REQ-022 A BLINK_PERIOD of 0 SHALL be treated as 1.
REQ-023 Each phase SHALL last exactly max(BLINK_PERIOD,1) cycles.
REQ-024 The period and count SHALL be latched at start; writes during a run SHALL affect only the next run.
REQ-025 A stop write SHALL force IDLE on the next cycle, does not set done, and takes priority over a simultaneous start.
REQ-026 A start written while busy SHALL be ignored.
REQ-027 The completed-pulse counter SHALL be 8 bits; in continuous mode it wraps 255->0 without terminating.
REQ-028 If a W1C clear of done or edge coincides with a new set event in the same cycle, the set SHALL win.
REQ-029 STATUS.busy SHALL be 1 in HIGH and LOW.
REQ-030 irq_o SHALL equal |(STATUS[2:1] & IRQ_EN[1:0]), registered.

Reset
REQ-031 On sys_rst all of the following SHALL be 0: wb_ack_o, wb_dat_o, gpio_out_pad, irq_o, DATA, OE, BLINK_CTRL count, IRQ_EN and all STATUS bits.
REQ-032 On sys_rst, gpio_oeb_pad SHALL be 1, BLINK_PERIOD SHALL be RST_HALF, and the FSM SHALL be IDLE.
REQ-033 Reset asserted mid-blink or mid-transfer SHALL abort immediately with no ack issued; the synchronizer flops SHALL also reset to 0.

Structure
REQ-034 Register offsets, field bit positions and the FSM state enumeration SHALL live in a shared package, mgmt_gpio_pkg.
REQ-035 The blink timer/FSM SHALL be one sub-module, gpio_blink_gen (inputs: start, stop, period, count; outputs: level, busy, done_pulse).
REQ-036 Both modules SHALL be synthesizable with no latches.

Verification
REQ-037 Reset, then read all registers -> reads return 0 except BLINK_PERIOD=1000; gpio_oeb_pad=1.
REQ-038 Write OE=1, DATA=1 -> gpio_oeb_pad=0 and gpio_out_pad=1 on the cycle after ack; DATA readback=0x1.
REQ-039 Run BLINK_PERIOD=4 with count=10 and start:
  - 10 pulses occur, each high 4 and low 4 cycles (80 cycles total).
  - Then done=1, busy=0, and gpio_out_pad returns to DATA.out.
  - This yields 10 falling edges, matching the bench monitor's expected blink count.
REQ-040 Run continuous mode with period=0 -> output toggles every cycle; a stop write returns the FSM to IDLE within 1 cycle with done=0.
REQ-041 With IRQ_EN=0x2, toggle gpio_in_pad -> edge and irq_o are set 3-4 cycles later; W1C of bit 2 clears both, and a same-cycle new edge keeps them set.
REQ-042 Assert sys_rst during the HIGH phase -> gpio_out_pad=0 and busy=0 immediately; the next start behaves as in REQ-039.
